// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter (8N1, or 8E1 when
// PARITY_EN=1). Bytes are queued on a valid/ready handshake and sent
// LSB first. Frames go out back-to-back with no idle gap while the
// FIFO holds data. The serial line, active and done outputs are all
// registered.
module uart_tx_fifo #(
    parameter int CLOCK_RATE = 16,
    parameter int BAUD_RATE  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    i_Tx_Byte,
    input  logic                          i_Tx_Valid,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Data,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    // Bit period in clocks, never below 2 so the baud counter has at least one bit.
    localparam int CPB_RAW      = CLOCK_RATE / BAUD_RATE;
    localparam int CLKS_PER_BIT = (CPB_RAW < 2) ? 2 : CPB_RAW;
    localparam int BW           = $clog2(CLKS_PER_BIT);
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam int CW           = PW + 1;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ZERO   = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            tx_q;
    logic            active_q;
    logic            done_q;

    logic            push_s;
    logic            pop_s;
    logic            baud_last_s;
    logic            fifo_nonempty_s;
    logic            line_s;

    assign o_Tx_Ready   = (count_q != COUNT_FULL);
    assign o_Tx_Data    = tx_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Done    = done_q;
    assign o_Fifo_Count = count_q;

    // Handshake qualification and shared status terms.
    always_comb begin
        push_s          = 1'b0;
        baud_last_s     = (baud_q == BAUD_LAST);
        fifo_nonempty_s = (count_q != COUNT_ZERO);
        if (i_Tx_Valid && o_Tx_Ready) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Transmit FSM: next state, baud/bit counters and shift register load.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = BAUD_ZERO;
                if (fifo_nonempty_s) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = 3'd0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_d  = BAUD_ZERO;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d = BAUD_ZERO;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_PARITY: begin
                if (baud_last_s) begin
                    baud_d  = BAUD_ZERO;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_d = BAUD_ZERO;
                    // Chain straight into the next frame when data is waiting.
                    if (fifo_nonempty_s) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        bit_d   = 3'd0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                baud_d  = BAUD_ZERO;
                bit_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level for the next cycle, derived from the next state so the output can be registered.
    always_comb begin
        line_s = 1'b1;
        case (state_d)
            ST_IDLE:   line_s = 1'b1;
            ST_START:  line_s = 1'b0;
            ST_DATA:   line_s = shift_d[bit_d];
            ST_PARITY: line_s = even_parity(shift_d);
            ST_STOP:   line_s = 1'b1;
            default:   line_s = 1'b1;
        endcase
    end

    // FIFO pointer and occupancy update; push and pop on one edge leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; an accepted byte is captured so later input changes cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    // State, counters and registered outputs; reset aborts any frame and empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= BAUD_ZERO;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= COUNT_ZERO;
            tx_q     <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tx_q     <= line_s;
            active_q <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_STOP) && (baud_d == BAUD_LAST);
        end
    end

endmodule
